// File: rtl/wb_pkg.sv
// Shared definitions for the write-back unit: default buffer depth,
// register-number and data widths, and the buffered write record.
package wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam int AW       = 5;
    localparam int DW       = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] wn;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending register writes.
// Accepts up to two pushes per cycle (push_a is the older of the pair and
// lands first) and one pop. The contents are also presented oldest-first,
// together with a per-slot valid flag, so the forwarding logic can find
// the youngest match without knowing where the read pointer sits.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_a,
    input  wb_entry_t                    push_a_entry,
    input  logic                         push_b,
    input  wb_entry_t                    push_b_entry,
    input  logic                         pop,
    output logic [$clog2(DEPTH):0]       count,
    output logic [DEPTH-1:0]             ord_valid,
    output wb_entry_t [DEPTH-1:0]        ord_entry
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         wr_ptr_b;

    // Second push goes one slot behind the first when both arrive together.
    always_comb begin
        wr_ptr_b = wr_ptr;
        if (push_a) begin
            wr_ptr_b = wr_ptr + PW'(1);
        end
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_a) begin
                mem[wr_ptr] <= push_a_entry;
            end
            if (push_b) begin
                mem[wr_ptr_b] <= push_b_entry;
            end
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    // Oldest-first view of the buffer: slot 0 is the head.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord_entry[i] = mem[rd_ptr + PW'(i)];
            ord_valid[i] = (CW'(i) < count);
        end
    end

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: merges execute results and load results into one
// in-order buffer and retires one register-file write per cycle through
// a registered write port.
// Optional feature macro: WB_FORWARD_EN enables the forwarding lookup on
// rna/rnb; without it the forwarding outputs are tied to zero.
module wb_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ex_valid,
    input  logic [AW-1:0] ex_wn,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_wn,
    input  logic [DW-1:0] mem_data,
    output logic          stall,
    output logic [AW-1:0] wn,
    output logic [DW-1:0] data,
    output logic          wwreg,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic          fwd_a_hit,
    output logic          fwd_b_hit,
    output logic [DW-1:0] fwd_a,
    output logic [DW-1:0] fwd_b
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LEVEL = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);

    logic [CW-1:0]         fifo_count;
    logic [DEPTH-1:0]      ord_valid;
    wb_entry_t [DEPTH-1:0] ord_entry;
    logic                  push_mem;
    logic                  push_ex;
    logic                  pop;
    wb_entry_t             mem_entry;
    wb_entry_t             ex_entry;

    // Back-pressure from registered occupancy; stalling one entry early
    // leaves room for a same-cycle load plus execute result.
    always_comb begin
        stall     = (fifo_count >= STALL_LEVEL);
        mem_ready = (fifo_count <  FULL_LEVEL);
    end

    // Accept logic; writes to register zero are discarded here.
    always_comb begin
        push_mem       = mem_valid && mem_ready && (mem_wn != REG_ZERO);
        push_ex        = ex_valid && !stall && (ex_wn != REG_ZERO);
        pop            = (fifo_count != '0);
        mem_entry.wn   = mem_wn;
        mem_entry.data = mem_data;
        ex_entry.wn    = ex_wn;
        ex_entry.data  = ex_data;
    end

    // The load result belongs to the older instruction, so it takes push_a.
    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_a       (push_mem),
        .push_a_entry (mem_entry),
        .push_b       (push_ex),
        .push_b_entry (ex_entry),
        .pop          (pop),
        .count        (fifo_count),
        .ord_valid    (ord_valid),
        .ord_entry    (ord_entry)
    );

    // Registered write port; wn/data hold their last value when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wwreg <= 1'b0;
            wn    <= '0;
            data  <= '0;
        end else begin
            wwreg <= pop;
            if (pop) begin
                wn   <= ord_entry[0].wn;
                data <= ord_entry[0].data;
            end
        end
    end

`ifdef WB_FORWARD_EN
    // Returns {hit, data} for the youngest pending write to rn; the output
    // register is oldest, then buffer slots from head to tail.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] rn);
        logic [DW:0] res;
        res = '0;
        if (rn != REG_ZERO) begin
            if (wwreg && (wn == rn)) begin
                res = {1'b1, data};
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ord_valid[i] && (ord_entry[i].wn == rn)) begin
                    res = {1'b1, ord_entry[i].data};
                end
            end
        end
        return res;
    endfunction

    // Forwarding comparators for both decode read ports.
    always_comb begin
        {fwd_a_hit, fwd_a} = lookup(rna);
        {fwd_b_hit, fwd_b} = lookup(rnb);
    end
`else
    logic unused_fwd;

    // Forwarding disabled: outputs tied off, lookup inputs intentionally idle.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_b_hit  = 1'b0;
        fwd_a      = '0;
        fwd_b      = '0;
        unused_fwd = &{1'b0, rna, rnb, ord_valid, ord_entry};
    end
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic, all compared every cycle
// against a queue-based model of the pending writes.
module tb_wb_unit;
    import wb_pkg::*;

    localparam int DEPTH = WB_DEPTH;

    logic          clock;
    logic          reset;
    logic          ex_valid;
    logic [AW-1:0] ex_wn;
    logic [DW-1:0] ex_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_wn;
    logic [DW-1:0] mem_data;
    logic          stall;
    logic [AW-1:0] wn;
    logic [DW-1:0] data;
    logic          wwreg;
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic          fwd_a_hit;
    logic          fwd_b_hit;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    wb_unit #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_wn     (ex_wn),
        .ex_data   (ex_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wn    (mem_wn),
        .mem_data  (mem_data),
        .stall     (stall),
        .wn        (wn),
        .data      (data),
        .wwreg     (wwreg),
        .rna       (rna),
        .rnb       (rnb),
        .fwd_a_hit (fwd_a_hit),
        .fwd_b_hit (fwd_b_hit),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] wn;
        logic [DW-1:0] data;
    } pend_t;

    typedef struct {
        logic          exv;
        logic [AW-1:0] exwn;
        logic [DW-1:0] exd;
        logic          memv;
        logic [AW-1:0] memwn;
        logic [DW-1:0] memd;
        logic          e_wwreg;
        logic [AW-1:0] e_wn;
        logic [DW-1:0] e_data;
        logic          e_stall;
    } vec_t;

    pend_t         q[$];
    logic          m_wwreg;
    logic [AW-1:0] m_wn;
    logic [DW-1:0] m_data;
    int            total;
    int            bad;

    task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW:0] modelFwd(input logic [AW-1:0] rn);
        logic [DW:0] r;
        r = '0;
`ifdef WB_FORWARD_EN
        if (rn != 0) begin
            if (m_wwreg && m_wn == rn) r = {1'b1, m_data};
            foreach (q[i]) if (q[i].wn == rn) r = {1'b1, q[i].data};
        end
`endif
        return r;
    endfunction

    task automatic checkOutput();
        logic [DW:0] fa;
        logic [DW:0] fb;
        fa = modelFwd(rna);
        fb = modelFwd(rnb);
        checkVal("stall", DW'(stall), DW'(q.size() >= DEPTH - 1));
        checkVal("mem_ready", DW'(mem_ready), DW'(q.size() < DEPTH));
        checkVal("wwreg", DW'(wwreg), DW'(m_wwreg));
        checkVal("wn", DW'(wn), DW'(m_wn));
        checkVal("data", data, m_data);
        checkVal("count", DW'(dut.fifo_count), DW'(q.size()));
        checkVal("fwd_a_hit", DW'(fwd_a_hit), DW'(fa[DW]));
        checkVal("fwd_a", fwd_a, fa[DW-1:0]);
        checkVal("fwd_b_hit", DW'(fwd_b_hit), DW'(fb[DW]));
        checkVal("fwd_b", fwd_b, fb[DW-1:0]);
    endtask

    // One cycle: drive at the falling edge, check, advance model at the rising edge.
    task automatic applyStimulus(input logic rst, input logic exv, input logic [AW-1:0] exwn,
                                 input logic [DW-1:0] exd, input logic memv,
                                 input logic [AW-1:0] memwn, input logic [DW-1:0] memd,
                                 input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        logic ex_acc;
        logic mem_acc;
        reset = rst; ex_valid = exv; ex_wn = exwn; ex_data = exd;
        mem_valid = memv; mem_wn = memwn; mem_data = memd; rna = ra; rnb = rb;
        #1;
        checkOutput();
        mem_acc = memv && (q.size() < DEPTH);
        ex_acc  = exv && (q.size() < DEPTH - 1);
        @(posedge clock);
        if (rst) begin
            q.delete();
            m_wwreg = 1'b0; m_wn = '0; m_data = '0;
        end else begin
            if (q.size() > 0) begin
                pend_t h;
                h = q.pop_front();
                m_wwreg = 1'b1; m_wn = h.wn; m_data = h.data;
            end else begin
                m_wwreg = 1'b0;
            end
            if (mem_acc && memwn != 0) q.push_back('{memwn, memd});
            if (ex_acc && exwn != 0) q.push_back('{exwn, exd});
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    vec_t vecs[7];
    logic stall_seen;
    int   idx;

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; ex_valid = 0; ex_wn = 0; ex_data = 0;
        mem_valid = 0; mem_wn = 0; mem_data = 0; rna = 0; rnb = 0;
        q.delete(); m_wwreg = 0; m_wn = 0; m_data = 0;

        vecs[0] = '{1, 3, 32'hA5, 0, 0, 0,  0, 0, 32'h0,  0};
        vecs[1] = '{1, 0, 32'h77, 0, 0, 0,  0, 0, 32'h0,  0};
        vecs[2] = '{1, 5, 32'h2,  1, 4, 1,  1, 3, 32'hA5, 0};
        vecs[3] = '{0, 0, 0,      0, 0, 0,  0, 3, 32'hA5, 0};
        vecs[4] = '{0, 0, 0,      0, 0, 0,  1, 4, 32'h1,  0};
        vecs[5] = '{0, 0, 0,      0, 0, 0,  1, 5, 32'h2,  0};
        vecs[6] = '{0, 0, 0,      0, 0, 0,  0, 5, 32'h2,  0};

        repeat (2) @(posedge clock);
        @(negedge clock);

        // Directed table: single write latency, register-zero drop, mem-before-ex order.
        for (int i = 0; i < 7; i++) begin
            reset = 0; ex_valid = vecs[i].exv; ex_wn = vecs[i].exwn; ex_data = vecs[i].exd;
            mem_valid = vecs[i].memv; mem_wn = vecs[i].memwn; mem_data = vecs[i].memd;
            #1;
            checkVal("tbl_wwreg", DW'(wwreg), DW'(vecs[i].e_wwreg));
            checkVal("tbl_wn", DW'(wn), DW'(vecs[i].e_wn));
            checkVal("tbl_data", data, vecs[i].e_data);
            checkVal("tbl_stall", DW'(stall), DW'(vecs[i].e_stall));
            #1;
            applyStimulus(0, vecs[i].exv, vecs[i].exwn, vecs[i].exd,
                          vecs[i].memv, vecs[i].memwn, vecs[i].memd, 0, 0);
        end

        // Continuous execute traffic with pulsing loads; ex held while stalled.
        stall_seen = 0;
        idx = 0;
        for (int k = 0; k < 40 && idx < 10; k++) begin
            logic [AW-1:0] ewn;
            ewn = AW'(idx % 7 + 1);
            stall_seen |= stall;
            if (q.size() < DEPTH - 1) begin
                applyStimulus(0, 1, ewn, DW'(idx + 100), (k % 2) == 0, AW'(k % 3 + 8), DW'(k), ewn, 8);
                idx++;
            end else begin
                applyStimulus(0, 1, ewn, DW'(idx + 100), (k % 2) == 0, AW'(k % 3 + 8), DW'(k), ewn, 8);
            end
        end
        checkVal("stall_seen", DW'(stall_seen), 1);
        idle(6);

        // Reset with three buffered writes: none may retire afterwards.
        applyStimulus(0, 1, 10, 32'h10, 1, 11, 32'h11, 0, 0);
        applyStimulus(0, 1, 12, 32'h12, 1, 13, 32'h13, 0, 0);
        checkVal("pre_reset_count", DW'(dut.fifo_count), 3);
        applyStimulus(1, 1, 14, 32'h14, 1, 15, 32'h15, 0, 0);
        checkVal("post_reset_wwreg", DW'(wwreg), 0);
        checkVal("post_reset_count", DW'(dut.fifo_count), 0);
        idle(4);

        // Two pending writes to the same register: youngest must be forwarded.
        applyStimulus(0, 1, 7, 32'h11, 0, 0, 0, 7, 0);
        applyStimulus(0, 1, 7, 32'h22, 0, 0, 0, 7, 0);
        rna = 7;
        #1;
`ifdef WB_FORWARD_EN
        checkVal("fwd6_hit", DW'(fwd_a_hit), 1);
        checkVal("fwd6_data", fwd_a, 32'h22);
`else
        checkVal("fwd6_hit", DW'(fwd_a_hit), 0);
        checkVal("fwd6_data", fwd_a, 0);
`endif
        rna = 0;
        #1;
        checkVal("fwd6_zero_hit", DW'(fwd_a_hit), 0);
        #1;
        idle(4);

        // Randomized traffic including occasional resets.
        for (int k = 0; k < 500; k++) begin
            applyStimulus($urandom_range(0, 59) == 0,
                          $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom,
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
